// File: rtl/decode_queue.sv
// Instruction decode queue: decodes each fetched word at enqueue and buffers
// the decoded result in a DEPTH-entry FIFO between fetch and issue.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [XLEN-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic [6:0]               out_opcode,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [2:0]               out_funct3,
   output logic [6:0]               out_funct7,
   output logic [XLEN-1:0]          out_imm,
   output logic [2:0]               out_fmt,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            push, pop;

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];
   logic [XLEN-1:0] imm_mem_q   [DEPTH];
   logic [2:0]      fmt_mem_q   [DEPTH];
   logic            ill_mem_q   [DEPTH];

   logic [6:0]      dec_op;
   logic [2:0]      dec_fmt;
   logic [63:0]     dec_imm64;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // Immediates are built at 64 bits and truncated so one expression serves both XLENs.
   assign dec_op = in_instr[6:0];
   always_comb begin
      dec_fmt   = 3'd7;
      dec_imm64 = '0;
      case (dec_op)
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0000111,
         7'b1110011, 7'b0011011, 7'b0001111: begin
            dec_fmt   = 3'd1;
            dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
         end
         7'b0100011, 7'b0100111: begin
            dec_fmt   = 3'd2;
            dec_imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         7'b1100011: begin
            dec_fmt   = 3'd3;
            dec_imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt   = 3'd4;
            dec_imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_fmt   = 3'd5;
            dec_imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
         end
         7'b0110011, 7'b0111011, 7'b0101111, 7'b1010011: dec_fmt = 3'd0;
         7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: dec_fmt = 3'd6;
         default: dec_fmt = 3'd7;
      endcase
   end
   assign dec_imm = dec_imm64[XLEN-1:0];

   // The W-variant opcodes only exist on RV64.
   assign dec_illegal = (in_instr[1:0] != 2'b11) || (dec_fmt == 3'd7) ||
                        ((XLEN == 32) && ((dec_op == 7'b0111011) || (dec_op == 7'b0011011))) ||
                        (in_instr == 32'h0000_0000) || (in_instr == 32'hFFFF_FFFF);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (rst) begin
            pc_mem_q[gi]    <= '0;
            instr_mem_q[gi] <= '0;
            imm_mem_q[gi]   <= '0;
            fmt_mem_q[gi]   <= '0;
            ill_mem_q[gi]   <= 1'b0;
         end else if (push && (wr_ptr_q == AW'(gi))) begin
            pc_mem_q[gi]    <= in_pc;
            instr_mem_q[gi] <= in_instr;
            imm_mem_q[gi]   <= dec_imm;
            fmt_mem_q[gi]   <= dec_fmt;
            ill_mem_q[gi]   <= dec_illegal;
         end
      end
   end

   assign out_pc      = pc_mem_q[rd_ptr_q];
   assign out_instr   = instr_mem_q[rd_ptr_q];
   assign out_imm     = imm_mem_q[rd_ptr_q];
   assign out_fmt     = fmt_mem_q[rd_ptr_q];
   assign out_illegal = ill_mem_q[rd_ptr_q];
   assign out_opcode  = out_instr[6:0];
   assign out_rd      = out_instr[11:7];
   assign out_funct3  = out_instr[14:12];
   assign out_rs1     = out_instr[19:15];
   assign out_rs2     = out_instr[24:20];
   assign out_funct7  = out_instr[31:25];
   assign count       = count_q;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the combinational instruction decoder: decodes each fetched 32-bit instruction at enqueue and buffers the decoded result in a DEPTH-entry FIFO between fetch and issue.
- Selects a single format-correct immediate, classifies the instruction format, and flags illegal encodings.
- Provides valid/ready handshakes on both sides and a synchronous flush for branch/trap redirects.

Parameters:
XLEN, 32, data/PC width; 32 or 64.
DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries and any concurrent enqueue
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; high when count < DEPTH
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid; high when count != 0
out_ready  in  1  issue consumes head
out_pc  out  XLEN  head PC
out_instr  out  32  head raw instruction
out_opcode  out  7  instr[6:0]
out_rd  out  5  instr[11:7]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  sign-extended immediate for the decoded format
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=R4 7=none
out_illegal  out  1  illegal/unsupported encoding
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- Push, pop, or both happen in one cycle; count changes by +1, -1, or 0.
- in_ready and out_valid are registered-state functions of count only; there is no combinational path from in_valid to out_valid and no bypass.
- Latency: an instruction pushed into an empty queue in cycle N is presented at the outputs in cycle N+1.
- Full (count == DEPTH): in_ready = 0. Pop is still allowed, and in_ready rises the cycle after the pop.
- Empty: out_valid = 0. A concurrent push makes the queue non-empty the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is the authoritative full/empty indicator.
- Out_* data fields come from the entry at rd_ptr. They are stable while out_valid = 1 and out_ready = 0.
- Immediate selection, decoded at push from in_instr:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, LOAD-FP 0000111, SYSTEM 1110011, OP-IMM-32 0011011, MISC-MEM 0001111.
  - S: STORE 0100011, STORE-FP 0100111.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - R: OP 0110011, OP-32 0111011, AMO 0101111, OP-FP 1010011.
  - R4: 1000011/1000111/1001011/1001111.
  - Other opcodes: fmt = 7 and imm = 0.
  - R and R4 formats set imm = 0.
- Immediate sign extension: bit 31 is replicated to XLEN. For I/S the sign bit is imm bit 11, for B bit 12, for J bit 20. U places instr[31:12] << 12, sign-extended above bit 31 when XLEN = 64.
- out_illegal = 1 when any of these holds:
  - instr[1:0] != 11;
  - fmt = 7;
  - XLEN == 32 and the opcode is OP-32 or OP-IMM-32;
  - instr == 0x00000000 or 0xFFFFFFFF.
- Illegal instructions are still queued; the issue stage raises the trap.
- flush: the next cycle count = 0, rd_ptr = wr_ptr = 0, out_valid = 0, in_ready = 1. Flush overrides push and pop in the same cycle.
- rst takes priority over flush and has the same effect. Additionally, all storage is cleared to 0.
- Reset values: out_valid 0, in_ready 1, count 0, all out_* data 0 (out_fmt 0, out_illegal 0).
- Reset asserted mid-stream drops all entries; no partial state survives.

Test Plan:
- Push ADDI 0x00500093 at pc 0x100 into an empty queue -> next cycle out_valid = 1, out_pc = 0x100, opcode 0x13, rd = 1, rs1 = 0, fmt = 1, imm = 5, illegal = 0.
- Push BEQ 0xFE000EE3, LUI 0x123452B7, JAL 0x008000EF back-to-back with out_ready = 1 -> in order:
  - imm 0xFFFFFFFC, fmt 3;
  - imm 0x12345000, fmt 4;
  - imm 8, fmt 5, rd = 1.
- Hold out_ready = 0 and push 5 instructions with DEPTH = 4 -> in_ready drops after the 4th push and count = 4. The 5th is accepted only after one pop, and wrap-around preserves FIFO order on drain.
- Full queue with simultaneous push and pop -> push is blocked (in_ready = 0), count goes 4 -> 3, then a push is accepted the following cycle.
- Queue holding 3 entries, flush asserted with in_valid = 1 -> next cycle count = 0 and out_valid = 0; the flushing-cycle instruction is not queued.
- Push 0x00000000 -> illegal = 1. With XLEN = 32 push ADDW 0x0000003B -> illegal = 1, fmt = 0. With XLEN = 64 the same word gives illegal = 0. Assert rst while 2 entries are held -> in_ready = 1, count = 0, all out_* = 0.
